// File: rtl/traffic_light_if.sv
// Lamp bundle for a two-direction traffic light.
// The controller drives all six lamps; observers only read them.
interface traffic_light_if;
  logic red1;
  logic yellow1;
  logic green1;
  logic red2;
  logic yellow2;
  logic green2;

  modport master (
    output red1,
    output yellow1,
    output green1,
    output red2,
    output yellow2,
    output green2
  );

  modport slave (
    input red1,
    input yellow1,
    input green1,
    input red2,
    input yellow2,
    input green2
  );
endinterface

// File: rtl/traffic_light.sv
// Two-direction traffic light: six-phase Moore FSM timed by a 32-bit phase counter.
// Lamps are registered from the next state, so they change on the same edge as the state.
module traffic_light #(
  parameter int unsigned GREEN_CYCLES   = 32'd160000000,
  parameter int unsigned YELLOW_CYCLES  = 32'd48000000,
  parameter int unsigned RED_RED_CYCLES = 32'd16000000
) (
  input logic             clk,
  input logic             rst,
  traffic_light_if.master lamps
);

  typedef enum logic [2:0] {
    StDir2Green  = 3'd0,
    StDir2Yellow = 3'd1,
    StClear2     = 3'd2,
    StDir1Green  = 3'd3,
    StDir1Yellow = 3'd4,
    StClear1     = 3'd5
  } state_e;

  // Lamp vector order: {red1, yellow1, green1, red2, yellow2, green2}
  localparam logic [5:0] LampDir2Green  = 6'b100_001;
  localparam logic [5:0] LampDir2Yellow = 6'b100_010;
  localparam logic [5:0] LampAllRed     = 6'b100_100;
  localparam logic [5:0] LampDir1Green  = 6'b001_100;
  localparam logic [5:0] LampDir1Yellow = 6'b010_100;

  localparam logic [31:0] GreenLen  = 32'(GREEN_CYCLES);
  localparam logic [31:0] YellowLen = 32'(YELLOW_CYCLES);
  localparam logic [31:0] ClearLen  = 32'(RED_RED_CYCLES);

  // Initializers match the reset values so the block runs correctly without a reset pulse.
  state_e      state_q = StDir2Green;
  state_e      state_d;
  logic [31:0] cnt_q   = '0;
  logic [31:0] cnt_d;
  logic [5:0]  lamp_q  = LampDir2Green;
  logic [5:0]  lamp_d;
  logic [31:0] phase_len;
  logic        phase_last;

  always_comb begin
    phase_len = 32'd1;
    case (state_q)
      StDir2Green,  StDir1Green:  phase_len = GreenLen;
      StDir2Yellow, StDir1Yellow: phase_len = YellowLen;
      StClear2,     StClear1:     phase_len = ClearLen;
      default:                    phase_len = 32'd1;
    endcase
  end

  // Lengths are at least 1, so the subtraction cannot wrap.
  assign phase_last = (cnt_q >= (phase_len - 32'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    case (state_q)
      StDir2Green:  if (phase_last) state_d = StDir2Yellow;
      StDir2Yellow: if (phase_last) state_d = StClear2;
      StClear2:     if (phase_last) state_d = StDir1Green;
      StDir1Green:  if (phase_last) state_d = StDir1Yellow;
      StDir1Yellow: if (phase_last) state_d = StClear1;
      StClear1:     if (phase_last) state_d = StDir2Green;
      default:      state_d = StDir2Green;
    endcase
    if (phase_last || (state_d != state_q)) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    lamp_d = LampDir2Green;
    case (state_d)
      StDir2Green:  lamp_d = LampDir2Green;
      StDir2Yellow: lamp_d = LampDir2Yellow;
      StClear2:     lamp_d = LampAllRed;
      StDir1Green:  lamp_d = LampDir1Green;
      StDir1Yellow: lamp_d = LampDir1Yellow;
      StClear1:     lamp_d = LampAllRed;
      default:      lamp_d = LampDir2Green;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StDir2Green;
      cnt_q   <= '0;
      lamp_q  <= LampDir2Green;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lamp_q  <= lamp_d;
    end
  end

  assign lamps.red1    = lamp_q[5];
  assign lamps.yellow1 = lamp_q[4];
  assign lamps.green1  = lamp_q[3];
  assign lamps.red2    = lamp_q[2];
  assign lamps.yellow2 = lamp_q[1];
  assign lamps.green2  = lamp_q[0];

endmodule

// File: tb/tb_traffic_light.sv
// Self-checking bench for traffic_light: a phase-table reference model checks every sampled
// cycle, plus reset, async-abort, power-up and unit-length-phase scenarios.
module tb_traffic_light;

  localparam int unsigned G      = 30;
  localparam int unsigned Y      = 5;
  localparam int unsigned R      = 3;
  localparam int unsigned PERIOD = 2 * (G + Y + R);

  localparam logic [5:0] PAT_S0 = 6'b100_001;

  logic clk       = 1'b0;
  logic rst       = 1'b0;
  logic rst_never = 1'b0;

  traffic_light_if if_a ();
  traffic_light_if if_b ();
  traffic_light_if if_c ();

  traffic_light #(
    .GREEN_CYCLES  (G),
    .YELLOW_CYCLES (Y),
    .RED_RED_CYCLES(R)
  ) dut_a (
    .clk  (clk),
    .rst  (rst),
    .lamps(if_a)
  );

  traffic_light #(
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .RED_RED_CYCLES(1)
  ) dut_b (
    .clk  (clk),
    .rst  (rst),
    .lamps(if_b)
  );

  traffic_light #(
    .GREEN_CYCLES  (G),
    .YELLOW_CYCLES (Y),
    .RED_RED_CYCLES(R)
  ) dut_c (
    .clk  (clk),
    .rst  (rst_never),
    .lamps(if_c)
  );

  always #5 clk = ~clk;

  logic [5:0] obs_a;
  logic [5:0] obs_b;
  logic [5:0] obs_c;
  assign obs_a = {if_a.red1, if_a.yellow1, if_a.green1, if_a.red2, if_a.yellow2, if_a.green2};
  assign obs_b = {if_b.red1, if_b.yellow1, if_b.green1, if_b.red2, if_b.yellow2, if_b.green2};
  assign obs_c = {if_c.red1, if_c.yellow1, if_c.green1, if_c.red2, if_c.yellow2, if_c.green2};

  int unsigned     checks  = 0;
  int unsigned     passed  = 0;
  longint unsigned elapsed = 0;

  // Lamps expected t clocks after the start of S0, walking the phase table.
  function automatic logic [5:0] model_lamps(input int unsigned g, input int unsigned y,
                                             input int unsigned r, input longint unsigned t);
    longint unsigned dur [6];
    logic [5:0]      pat [6];
    longint unsigned p;
    dur[0] = g; dur[1] = y; dur[2] = r; dur[3] = g; dur[4] = y; dur[5] = r;
    pat[0] = 6'b100_001; pat[1] = 6'b100_010; pat[2] = 6'b100_100;
    pat[3] = 6'b001_100; pat[4] = 6'b010_100; pat[5] = 6'b100_100;
    p = t % (2 * (longint'(g) + longint'(y) + longint'(r)));
    for (int i = 0; i < 6; i++) begin
      if (p < dur[i]) return pat[i];
      p -= dur[i];
    end
    return 6'b000_000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    elapsed++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    elapsed = 0;
  endtask

  task automatic test_power_up();
    int first_y;
    logic [5:0] exp;
    first_y = -1;
    #1;
    checks++;
    if (obs_c !== PAT_S0) $display("FAIL power_up_initial: got %b want %b", obs_c, PAT_S0);
    else passed++;
    for (int k = 1; k <= 100 && first_y < 0; k++) begin
      @(posedge clk);
      #1;
      if (k <= 40) begin
        exp = model_lamps(G, Y, R, longint'(k));
        checks++;
        if (obs_c !== exp) $display("FAIL power_up_seq: k=%0d got %b want %b", k, obs_c, exp);
        else passed++;
      end
      if (obs_c[1] === 1'b1) first_y = k;
    end
    checks++;
    if (first_y != int'(G)) $display("FAIL power_up_first_y2: got %0d want %0d", first_y, G);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_a !== PAT_S0) $display("FAIL reset_async: got %b want %b", obs_a, PAT_S0);
    else passed++;
    repeat (3) begin
      step();
      checks++;
      if (obs_a !== PAT_S0) $display("FAIL reset_held: got %b want %b", obs_a, PAT_S0);
      else passed++;
    end
    @(negedge clk);
    rst     = 1'b0;
    elapsed = 0;
    #1;
    checks++;
    if (obs_a !== PAT_S0) $display("FAIL reset_release: got %b want %b", obs_a, PAT_S0);
    else passed++;
  endtask

  task automatic test_sequence();
    logic [5:0]  seq [PERIOD + 1];
    int unsigned seg_len [6];
    int unsigned want_len [6];
    int          idx;
    logic [5:0]  exp;
    pulse_reset();
    seq[0] = obs_a;
    for (int k = 1; k <= int'(2 * PERIOD); k++) begin
      step();
      exp = model_lamps(G, Y, R, elapsed);
      checks++;
      if (obs_a !== exp) $display("FAIL sequence: t=%0d got %b want %b", elapsed, obs_a, exp);
      else passed++;
      if (k <= int'(PERIOD)) seq[k] = obs_a;
    end
    want_len[0] = G; want_len[1] = Y; want_len[2] = R;
    want_len[3] = G; want_len[4] = Y; want_len[5] = R;
    for (int i = 0; i < 6; i++) seg_len[i] = 0;
    idx        = 0;
    seg_len[0] = 1;
    for (int k = 1; k < int'(PERIOD); k++) begin
      if (seq[k] !== seq[k-1]) idx++;
      if (idx < 6) seg_len[idx]++;
    end
    checks++;
    if (idx != 5) $display("FAIL segment_count: got %0d want 6", idx + 1);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seg_len[i] != want_len[i])
        $display("FAIL segment_len[%0d]: got %0d want %0d", i, seg_len[i], want_len[i]);
      else passed++;
    end
    checks++;
    if (seq[PERIOD] !== PAT_S0) $display("FAIL period_wrap: got %b want %b", seq[PERIOD], PAT_S0);
    else passed++;
  endtask

  task automatic test_safety();
    logic [5:0] exp;
    pulse_reset();
    for (int k = 0; k < int'(10 * PERIOD); k++) begin
      step();
      exp = model_lamps(G, Y, R, elapsed);
      checks++;
      if (obs_a !== exp) $display("FAIL safety_model: t=%0d got %b want %b", elapsed, obs_a, exp);
      else passed++;
      checks++;
      if ($countones(obs_a[5:3]) != 1 || $countones(obs_a[2:0]) != 1)
        $display("FAIL one_lamp_per_dir: t=%0d got %b want one-hot per direction", elapsed, obs_a);
      else passed++;
      checks++;
      if ((obs_a[3] && obs_a[0]) || (obs_a[3] && obs_a[1]) || (obs_a[0] && obs_a[4]))
        $display("FAIL green_conflict: t=%0d got %b want no conflict", elapsed, obs_a);
      else passed++;
    end
  endtask

  task automatic test_async_abort();
    logic [5:0] exp;
    pulse_reset();
    repeat (G + Y + R + 15) step();
    checks++;
    if (obs_a !== 6'b001_100) $display("FAIL abort_in_s3: got %b want %b", obs_a, 6'b001_100);
    else passed++;
    #($urandom_range(1, 7));
    rst = 1'b1;
    #1;
    checks++;
    if (obs_a !== PAT_S0) $display("FAIL abort_immediate: got %b want %b", obs_a, PAT_S0);
    else passed++;
    @(negedge clk);
    rst     = 1'b0;
    elapsed = 0;
    for (int k = 0; k < int'(G + Y + 2); k++) begin
      step();
      exp = model_lamps(G, Y, R, elapsed);
      checks++;
      if (obs_a !== exp) $display("FAIL abort_resume: t=%0d got %b want %b", elapsed, obs_a, exp);
      else passed++;
    end
  endtask

  task automatic test_random_reset();
    logic [5:0] exp;
    int         n;
    pulse_reset();
    repeat (8) begin
      n = int'($urandom_range(1, 200));
      for (int k = 0; k < n; k++) begin
        step();
        exp = model_lamps(G, Y, R, elapsed);
        checks++;
        if (obs_a !== exp) $display("FAIL random_run: t=%0d got %b want %b", elapsed, obs_a, exp);
        else passed++;
      end
      #($urandom_range(1, 7));
      rst = 1'b1;
      #1;
      checks++;
      if (obs_a !== PAT_S0) $display("FAIL random_reset: got %b want %b", obs_a, PAT_S0);
      else passed++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(negedge clk);
      rst     = 1'b0;
      elapsed = 0;
    end
  endtask

  task automatic test_unit_params();
    logic [5:0] exp;
    pulse_reset();
    #1;
    checks++;
    if (obs_b !== PAT_S0) $display("FAIL unit_release: got %b want %b", obs_b, PAT_S0);
    else passed++;
    for (int k = 0; k < 18; k++) begin
      step();
      exp = model_lamps(1, 1, 1, elapsed);
      checks++;
      if (obs_b !== exp) $display("FAIL unit_seq: t=%0d got %b want %b", elapsed, obs_b, exp);
      else passed++;
    end
  endtask

  initial begin
    test_power_up();
    test_reset();
    test_sequence();
    test_safety();
    test_async_abort();
    test_random_reset();
    test_unit_params();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
